// File: rtl/cv32e40s_rvfi_obi_txn_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cv32e40s_rvfi_obi_txn_tracker                                              |
// | Pairs data OBI grants with in-order responses; emits completed records.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cv32e40s_rvfi_obi_txn_tracker #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      obi_req_i,
  input  logic                      obi_gnt_i,
  input  logic [ADDR_WIDTH-1:0]     obi_addr_i,
  input  logic                      obi_we_i,
  input  logic [DATA_WIDTH/8-1:0]   obi_be_i,
  input  logic [DATA_WIDTH-1:0]     obi_wdata_i,
  input  logic                      obi_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     obi_rdata_i,
  input  logic                      obi_err_i,
  output logic                      txn_valid_o,
  input  logic                      txn_ready_i,
  output logic [ADDR_WIDTH-1:0]     txn_addr_o,
  output logic                      txn_we_o,
  output logic [DATA_WIDTH/8-1:0]   txn_be_o,
  output logic [DATA_WIDTH-1:0]     txn_wdata_o,
  output logic [DATA_WIDTH-1:0]     txn_rdata_o,
  output logic                      txn_err_o,
  output logic [$clog2(DEPTH):0]    outstanding_o,
  output logic [$clog2(DEPTH):0]    occupancy_o,
  output logic                      proto_err_o
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam logic [PTR_WIDTH:0] PTR_ONE   = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] addr_q  [DEPTH];
  logic                  we_q    [DEPTH];
  logic [BE_WIDTH-1:0]   be_q    [DEPTH];
  logic [DATA_WIDTH-1:0] wdata_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q [DEPTH];
  logic                  err_q   [DEPTH];
  logic [DEPTH-1:0]      done_q;

  logic [PTR_WIDTH:0]    wr_ptr;
  logic [PTR_WIDTH:0]    rsp_ptr;
  logic [PTR_WIDTH:0]    rd_ptr;
  logic                  proto_err_q;

  logic [PTR_WIDTH-1:0]  wr_idx;
  logic [PTR_WIDTH-1:0]  rsp_idx;
  logic [PTR_WIDTH-1:0]  rd_idx;
  logic [PTR_WIDTH:0]    occupancy;
  logic [PTR_WIDTH:0]    outstanding;
  logic                  full;
  logic                  push_req;
  logic                  push;
  logic                  rsp;
  logic                  pop;
  logic                  valid;

  assign wr_idx      = wr_ptr[PTR_WIDTH-1:0];
  assign rsp_idx     = rsp_ptr[PTR_WIDTH-1:0];
  assign rd_idx      = rd_ptr[PTR_WIDTH-1:0];
  assign occupancy   = wr_ptr - rd_ptr;
  assign outstanding = wr_ptr - rsp_ptr;
  assign full        = (occupancy == DEPTH_CNT);

  // Full/outstanding are judged on the pre-cycle pointers: a same-cycle pop
  // does not make room, and a same-cycle grant cannot already be answered.
  assign push_req = obi_req_i && obi_gnt_i;
  assign push     = push_req && !full;
  assign rsp      = obi_rvalid_i && (outstanding != '0);
  assign valid    = (occupancy != '0) && done_q[rd_idx];
  assign pop      = valid && txn_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rsp_ptr     <= '0;
      rd_ptr      <= '0;
      proto_err_q <= 1'b0;
      done_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        we_q[i]    <= 1'b0;
        be_q[i]    <= '0;
        wdata_q[i] <= '0;
        rdata_q[i] <= '0;
        err_q[i]   <= 1'b0;
      end
    end else begin
      if (push) begin
        addr_q[wr_idx]  <= obi_addr_i;
        we_q[wr_idx]    <= obi_we_i;
        be_q[wr_idx]    <= obi_be_i;
        wdata_q[wr_idx] <= obi_wdata_i;
        done_q[wr_idx]  <= 1'b0;
        wr_ptr          <= wr_ptr + PTR_ONE;
      end
      if (rsp) begin
        rdata_q[rsp_idx] <= obi_rdata_i;
        err_q[rsp_idx]   <= obi_err_i;
        done_q[rsp_idx]  <= 1'b1;
        rsp_ptr          <= rsp_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if ((push_req && full) || (obi_rvalid_i && (outstanding == '0))) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign txn_valid_o   = valid;
  assign txn_addr_o    = addr_q[rd_idx];
  assign txn_we_o      = we_q[rd_idx];
  assign txn_be_o      = be_q[rd_idx];
  assign txn_wdata_o   = wdata_q[rd_idx];
  assign txn_rdata_o   = rdata_q[rd_idx];
  assign txn_err_o     = err_q[rd_idx];
  assign outstanding_o = outstanding;
  assign occupancy_o   = occupancy;
  assign proto_err_o   = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40s_rvfi_obi_txn_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cv32e40s_rvfi_obi_txn_tracker                                           |
// | Directed self-checking bench for the OBI transaction tracker.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_cv32e40s_rvfi_obi_txn_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        obi_req, obi_gnt, obi_we, obi_rvalid, obi_err, txn_ready;
  logic [31:0] obi_addr, obi_wdata, obi_rdata;
  logic [3:0]  obi_be;
  logic        txn_valid, txn_we, txn_err, proto_err;
  logic [31:0] txn_addr, txn_wdata, txn_rdata;
  logic [3:0]  txn_be;
  logic [2:0]  outstanding, occupancy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cv32e40s_rvfi_obi_txn_tracker #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .obi_req_i    (obi_req),
    .obi_gnt_i    (obi_gnt),
    .obi_addr_i   (obi_addr),
    .obi_we_i     (obi_we),
    .obi_be_i     (obi_be),
    .obi_wdata_i  (obi_wdata),
    .obi_rvalid_i (obi_rvalid),
    .obi_rdata_i  (obi_rdata),
    .obi_err_i    (obi_err),
    .txn_valid_o  (txn_valid),
    .txn_ready_i  (txn_ready),
    .txn_addr_o   (txn_addr),
    .txn_we_o     (txn_we),
    .txn_be_o     (txn_be),
    .txn_wdata_o  (txn_wdata),
    .txn_rdata_o  (txn_rdata),
    .txn_err_o    (txn_err),
    .outstanding_o(outstanding),
    .occupancy_o  (occupancy),
    .proto_err_o  (proto_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    obi_req = 0; obi_gnt = 0; obi_addr = '0; obi_we = 0; obi_be = '0;
    obi_wdata = '0; obi_rvalid = 0; obi_rdata = '0; obi_err = 0;
  endtask

  task automatic grant(input logic [31:0] a, input logic w, input logic [31:0] wd);
    obi_req = 1; obi_gnt = 1; obi_addr = a; obi_we = w; obi_be = 4'hF; obi_wdata = wd;
  endtask

  task automatic respond(input logic [31:0] rd, input logic e);
    obi_rvalid = 1; obi_rdata = rd; obi_err = e;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 0;
    #1;
    check("rst_valid", txn_valid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_out", outstanding, 0);
    check("rst_perr", proto_err, 0);
    check("rst_addr", txn_addr, 0);
    check("rst_wdata", txn_wdata, 0);
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    rst_n = 0; txn_ready = 0;
    idle();
    tick(); tick();
    check("init_valid", txn_valid, 0);
    check("init_occ", occupancy, 0);
    check("init_perr", proto_err, 0);
    rst_n = 1;

    // Single read
    txn_ready = 1;
    grant(32'h1000, 0, 32'h0);
    tick();
    check("t1_occ", occupancy, 1);
    check("t1_out", outstanding, 1);
    idle();
    tick();
    respond(32'hDEADBEEF, 0);
    check("t1_valid_early", txn_valid, 0);
    tick();
    idle();
    check("t1_valid", txn_valid, 1);
    check("t1_addr", txn_addr, 32'h1000);
    check("t1_we", txn_we, 0);
    check("t1_rdata", txn_rdata, 32'hDEADBEEF);
    check("t1_err", txn_err, 0);
    check("t1_out0", outstanding, 0);
    tick();
    check("t1_valid_after", txn_valid, 0);
    check("t1_occ_after", occupancy, 0);

    // Four pipelined grants, then responses, consumer stalled
    txn_ready = 0;
    for (int i = 0; i < 4; i++) begin
      grant(32'(4*i), 0, 32'h0);
      tick();
    end
    check("t2_occ", occupancy, 4);
    check("t2_out", outstanding, 4);
    for (int i = 0; i < 4; i++) begin
      idle();
      respond(32'h100 + 32'(i), 0);
      tick();
      check("t2_out_dec", outstanding, 3 - i);
    end
    idle();
    check("t2_valid", txn_valid, 1);
    check("t2_head", txn_addr, 0);
    tick();
    check("t2_stable_v", txn_valid, 1);
    check("t2_stable_a", txn_addr, 0);

    // Overflow while full
    grant(32'h100, 0, 32'h0);
    tick();
    idle();
    check("t3_occ", occupancy, 4);
    check("t3_perr", proto_err, 1);
    check("t3_head", txn_addr, 0);
    txn_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check("t3_pop_v", txn_valid, 1);
      check("t3_pop_a", txn_addr, 32'(4*i));
      check("t3_pop_d", txn_rdata, 32'h100 + 32'(i));
      tick();
    end
    check("t3_occ0", occupancy, 0);
    check("t3_valid0", txn_valid, 0);
    check("t3_perr_sticky", proto_err, 1);
    pulse_reset();

    // Simultaneous push, response and pop
    txn_ready = 0;
    grant(32'h200, 1, 32'h1111);
    tick();
    grant(32'h204, 0, 32'h0);
    tick();
    idle();
    respond(32'hAAAA, 0);
    tick();
    idle();
    check("t4_occ2", occupancy, 2);
    check("t4_out1", outstanding, 1);
    grant(32'h208, 0, 32'h0);
    respond(32'hBBBB, 1);
    txn_ready = 1;
    check("t4_pop_v", txn_valid, 1);
    check("t4_pop_a", txn_addr, 32'h200);
    check("t4_pop_we", txn_we, 1);
    check("t4_pop_wd", txn_wdata, 32'h1111);
    check("t4_pop_rd", txn_rdata, 32'hAAAA);
    tick();
    idle();
    check("t4_occ", occupancy, 2);
    check("t4_out", outstanding, 1);
    check("t4_next_a", txn_addr, 32'h204);
    check("t4_next_rd", txn_rdata, 32'hBBBB);
    check("t4_next_err", txn_err, 1);
    tick();
    check("t4_c_wait", txn_valid, 0);
    respond(32'hCCCC, 0);
    tick();
    idle();
    check("t4_c_a", txn_addr, 32'h208);
    check("t4_c_v", txn_valid, 1);
    tick();
    check("t4_occ0", occupancy, 0);
    check("t4_perr", proto_err, 0);

    // Spurious rvalid, and ready without valid
    respond(32'h5555, 0);
    tick();
    idle();
    check("t5_valid", txn_valid, 0);
    check("t5_occ", occupancy, 0);
    check("t5_out", outstanding, 0);
    check("t5_perr", proto_err, 1);
    tick();
    check("t5_occ_idle", occupancy, 0);
    pulse_reset();

    // Ten serial writes wrap the pointers twice
    txn_ready = 1;
    for (int i = 0; i < 10; i++) begin
      grant(32'h3000 + 32'(4*i), 1, 32'hA5A5_0000 + 32'(i));
      tick();
      idle();
      respond(32'h0, 0);
      tick();
      idle();
      check("t6_v", txn_valid, 1);
      check("t6_a", txn_addr, 32'h3000 + 32'(4*i));
      check("t6_wd", txn_wdata, 32'hA5A5_0000 + 32'(i));
      tick();
    end
    check("t6_occ0", occupancy, 0);
    check("t6_perr", proto_err, 0);

    // Mid-burst reset with two outstanding
    grant(32'h5000, 1, 32'h77);
    tick();
    grant(32'h5004, 1, 32'h88);
    tick();
    idle();
    check("t7_out2", outstanding, 2);
    pulse_reset();
    grant(32'h4000, 0, 32'h0);
    tick();
    idle();
    respond(32'h12345678, 1);
    tick();
    idle();
    check("t7_v", txn_valid, 1);
    check("t7_a", txn_addr, 32'h4000);
    check("t7_rd", txn_rdata, 32'h12345678);
    check("t7_err", txn_err, 1);
    tick();
    check("t7_occ0", occupancy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cv32e40s_rvfi_obi_txn_tracker.md
Name: cv32e40s_rvfi_obi_txn_tracker

Overview:
- Sits directly upstream of the RVFI data OBI aligner, tapping the core's data OBI bus.
- Pairs each granted address phase with its in-order response phase (rvalid) and emits one completed transaction record per access over a valid/ready handshake.
- The downstream aligner retimes each record to writeback.
- Bookkeeping and records only; never drives the OBI bus.

Parameters:
- DEPTH, 4: max outstanding plus unconsumed transactions; power of 2 (pointer wrap arithmetic).
- ADDR_WIDTH, 32: OBI address width.
- DATA_WIDTH, 32: OBI data width; byte-enable width is DATA_WIDTH/8.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- obi_req_i  in  1  data OBI req.
- obi_gnt_i  in  1  data OBI gnt.
- obi_addr_i  in  ADDR_WIDTH  address-phase address.
- obi_we_i  in  1  write enable.
- obi_be_i  in  DATA_WIDTH/8  byte enables.
- obi_wdata_i  in  DATA_WIDTH  write data.
- obi_rvalid_i  in  1  response valid.
- obi_rdata_i  in  DATA_WIDTH  read data.
- obi_err_i  in  1  bus error (qualified by rvalid).
- txn_valid_o  out  1  head record complete and presented.
- txn_ready_i  in  1  consumer accepts record.
- txn_addr_o, txn_we_o, txn_be_o, txn_wdata_o  out  as inputs  captured address-phase fields.
- txn_rdata_o  out  DATA_WIDTH  captured rdata (captured for writes as well).
- txn_err_o  out  1  captured err.
- outstanding_o  out  PTR_WIDTH+1  granted, not yet responded.
- occupancy_o  out  PTR_WIDTH+1  granted, not yet popped.
- proto_err_o  out  1  sticky protocol violation flag.

Behaviour:
- Storage: DEPTH-entry circular buffer. Pointers wr_ptr, rsp_ptr, rd_ptr are PTR_WIDTH+1 bits (extra MSB marks wrap).
  - occupancy = wr_ptr - rd_ptr; outstanding = wr_ptr - rsp_ptr.
  - Full when occupancy == DEPTH.
- Push: obi_req_i && obi_gnt_i. Writes addr/we/be/wdata at wr_ptr, clears the entry's done bit, increments wr_ptr.
- Response: obi_rvalid_i with outstanding != 0 (value before this cycle's push). Writes rdata/err at rsp_ptr, sets done, increments rsp_ptr.
  - A push in the same cycle is not visible to that cycle's rvalid (OBI rvalid is ≥1 cycle after gnt).
- Output:
  - txn_valid_o = (occupancy != 0) && done[rd_ptr], with all txn_* fields read from entry rd_ptr.
  - Pop on txn_valid_o && txn_ready_i; increments rd_ptr.
  - Records leave strictly in grant order.
- Latency: rvalid in cycle N gives txn_valid_o high in cycle N+1 at the earliest. No combinational path from obi_* to txn_*.
- Push, response and pop may all occur in the same cycle. Counters are updated from the net effect.
- Boundary conditions:
  - Push while full (before this cycle's pop): entry dropped, pointers unchanged, proto_err_o set.
  - rvalid while outstanding == 0: ignored, proto_err_o set.
  - txn_ready_i without txn_valid_o: no effect.
  - txn_valid_o remains high with stable fields until popped.
  - Pointer wrap: the MSB toggles, and full/empty remain distinguishable.
- proto_err_o is sticky until reset.
- Reset (asynchronous, mid-operation included): all pointers 0, done bits 0, proto_err_o 0. txn_valid_o, outstanding_o and occupancy_o read 0. txn_* data outputs read 0 (entry storage reset to 0). In-flight transactions are discarded.

Test Plan:
- Single read: gnt at cycle 1 with addr 0x1000, rvalid at cycle 3 with rdata 0xDEADBEEF and txn_ready_i=1 → txn_valid_o high only at cycle 4 with addr 0x1000, we=0, rdata 0xDEADBEEF, err=0; occupancy returns to 0.
- Pipelined 4 grants back-to-back (0x0, 0x4, 0x8, 0xC), with rvalids starting the cycle after the last gnt and txn_ready_i=0 → occupancy_o=4, outstanding_o falls 4→0. Then raise txn_ready_i → four records in address order, one per cycle.
- Full overflow: with 4 entries unconsumed, a 5th req&&gnt → entry dropped, occupancy_o stays 4, proto_err_o=1 and stays 1.
- Simultaneous events: occupancy 2 with 1 outstanding; in one cycle apply push, rvalid and pop → occupancy stays 2, outstanding stays 1, popped record correct.
- Spurious rvalid with nothing outstanding → no record produced, proto_err_o=1.
- Wrap plus reset: stream 10 transactions (pointers wrap twice), checking order and write data 0xA5A5_0000+i. Then assert rst_n low mid-burst with 2 outstanding → all outputs 0 immediately, and a subsequent fresh transaction works normally.
